// File: rtl/mvm_result_serializer_if.sv
// Byte stream handshake carrying serialized matvec results toward the UART transmitter.
interface mvm_result_serializer_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/mvm_result_serializer.sv
// Flushes the matvec_mul pipeline with its clock enable, captures the R results and
// streams them out row by row, least significant byte first.
module mvm_result_serializer #(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    output logic                                    cen_o,
    input  logic [R*(W_X+W_K+$clog2(C))-1:0]        yf,
    mvm_result_serializer_if.master                 tx,
    output logic                                    busy,
    output logic                                    done
);

    localparam int DEPTH  = $clog2(C);
    localparam int W_Y    = W_X + W_K + DEPTH;
    localparam int LAT    = DEPTH + 1;
    localparam int NB     = (W_Y + 7) / 8;
    localparam int NBYTES = R * NB;
    localparam int IW     = $clog2(NBYTES + 1);
    localparam int FW     = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, FILL, LOAD, SEND} state_t;

    state_t              state;
    logic [FW-1:0]       fillCnt;
    logic [IW-1:0]       byteIdx;
    logic [NBYTES*8-1:0] capVec;
    logic [NBYTES*8-1:0] capBuf;

    // Each row is sign-extended to a whole number of bytes so the stream is byte aligned.
    always_comb begin
        capVec = '0;
        for (int r = 0; r < R; r++) begin
            capVec[r*NB*8 +: NB*8] = (NB*8)'($signed(yf[r*W_Y +: W_Y]));
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            capBuf <= capVec;
        end
    end

    // Byte 0 comes straight from the capture vector because the buffer loads on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cen_o      <= 1'b0;
            tx.m_valid <= 1'b0;
            tx.m_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fillCnt    <= '0;
            byteIdx    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FILL;
                        cen_o   <= 1'b1;
                        busy    <= 1'b1;
                        fillCnt <= '0;
                    end
                end
                FILL: begin
                    if (fillCnt == FW'(LAT - 1)) begin
                        cen_o <= 1'b0;
                        state <= LOAD;
                    end else begin
                        fillCnt <= fillCnt + FW'(1);
                    end
                end
                LOAD: begin
                    state      <= SEND;
                    tx.m_valid <= 1'b1;
                    tx.m_data  <= capVec[7:0];
                    byteIdx    <= '0;
                end
                SEND: begin
                    if (tx.m_valid && tx.m_ready) begin
                        if (byteIdx == IW'(NBYTES - 1)) begin
                            state      <= IDLE;
                            tx.m_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            byteIdx   <= byteIdx + IW'(1);
                            tx.m_data <= capBuf[(int'(byteIdx) + 1) * 8 +: 8];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_result_serializer.sv
// Directed and randomized runs of the result serializer against an arithmetic model of
// the matrix-vector product and a LAT-stage enable-gated stand-in for matvec_mul.
module tb_mvm_result_serializer;

    localparam int R      = 8;
    localparam int C      = 8;
    localparam int W_X    = 8;
    localparam int W_K    = 8;
    localparam int DEPTH  = $clog2(C);
    localparam int W_Y    = W_X + W_K + DEPTH;
    localparam int LAT    = DEPTH + 1;
    localparam int NB     = (W_Y + 7) / 8;
    localparam int NBYTES = R * NB;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cen_o;
    logic             busy;
    logic             done;
    logic [R*W_Y-1:0] yf;
    logic [R*W_Y-1:0] yTarget;
    logic [R*W_Y-1:0] junkVal;
    logic [R*W_Y-1:0] pipe [LAT];
    bit               garble;

    int         kMat [R][C];
    int         xVec [C];
    int         yRef [R];
    logic [7:0] expBytes [NBYTES];

    int total = 0;
    int bad   = 0;

    mvm_result_serializer_if txIf ();

    mvm_result_serializer #(.R(R), .C(C), .W_X(W_X), .W_K(W_K)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cen_o (cen_o),
        .yf    (yf),
        .tx    (txIf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Stand-in for matvec_mul: the product only reaches yf after LAT enabled edges.
    always @(posedge clk) begin
        if (cen_o) begin
            pipe[0] <= yTarget;
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign yf = garble ? junkVal : pipe[LAT-1];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int pattern);
        for (int c = 0; c < C; c++) begin
            case (pattern)
                0:       xVec[c] = c + 1;
                1, 2:    xVec[c] = -128;
                default: xVec[c] = int'($urandom_range(255)) - 128;
            endcase
        end
        for (int r = 0; r < R; r++) begin
            yRef[r] = 0;
            for (int c = 0; c < C; c++) begin
                case (pattern)
                    0:       kMat[r][c] = (r == c) ? 1 : 0;
                    1:       kMat[r][c] = -128;
                    2:       kMat[r][c] = 127;
                    default: kMat[r][c] = int'($urandom_range(255)) - 128;
                endcase
                yRef[r] = yRef[r] + kMat[r][c] * xVec[c];
            end
            yTarget[r*W_Y +: W_Y] = W_Y'(yRef[r]);
            for (int b = 0; b < NB; b++) begin
                expBytes[r*NB + b] = 8'(yRef[r] >>> (8 * b));
            end
        end
    endtask

    task automatic resetAndCheck();
        rst = 1'b1;
        #1;
        checkVal("rst_valid", 32'(txIf.m_valid), 32'd0);
        checkVal("rst_data",  32'(txIf.m_data),  32'd0);
        checkVal("rst_cen",   32'(cen_o),        32'd0);
        checkVal("rst_busy",  32'(busy),         32'd0);
        checkVal("rst_done",  32'(done),         32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // readyMode 0: always ready, 1: 10-cycle stall at byte 4 then random, 2: random.
    task automatic checkOutput(input string name, input int readyMode, input int abortAt,
                               input bit pokeStart);
        int         got        = 0;
        int         cyc        = 0;
        int         cenCnt     = 0;
        int         firstValid = -1;
        int         stallCnt   = 0;
        bit         stalled    = 1'b0;
        bit         rdy;
        logic [7:0] heldData   = '0;

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkVal({name, "_done_clear"}, 32'(done), 32'd0);
        while (got < NBYTES && cyc < 600) begin
            if (cen_o) cenCnt++;
            if (txIf.m_valid && firstValid < 0) begin
                firstValid = cyc;
                garble     = 1'b1;
            end
            if (garble) begin
                for (int i = 0; i < R*W_Y; i++) junkVal[i] = 1'($urandom);
            end
            if (stalled) begin
                checkVal({name, "_stall_data"},  32'(txIf.m_data),  32'(heldData));
                checkVal({name, "_stall_valid"}, 32'(txIf.m_valid), 32'd1);
            end
            checkVal({name, "_busy"}, 32'(busy), 32'd1);
            if (abortAt >= 0 && got == abortAt && txIf.m_valid) begin
                rst = 1'b1;
                #1;
                checkVal({name, "_abort_valid"}, 32'(txIf.m_valid), 32'd0);
                checkVal({name, "_abort_cen"},   32'(cen_o),        32'd0);
                checkVal({name, "_abort_busy"},  32'(busy),         32'd0);
                @(posedge clk);
                #1;
                rst    = 1'b0;
                garble = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    checkVal({name, "_abort_quiet"}, 32'(txIf.m_valid), 32'd0);
                end
                return;
            end
            if (readyMode == 0)                       rdy = 1'b1;
            else if (readyMode == 1 && got < 4)       rdy = 1'b1;
            else if (readyMode == 1 && got == 4 && stallCnt < 10) begin
                rdy = 1'b0;
                stallCnt++;
            end
            else                                      rdy = 1'($urandom);
            start          = pokeStart && (cyc == 1 || got == 10);
            txIf.m_ready   = rdy;
            if (txIf.m_valid && rdy) begin
                checkVal({name, "_byte"}, 32'(txIf.m_data), 32'(expBytes[got]));
                got++;
                stalled = 1'b0;
            end else begin
                stalled  = txIf.m_valid;
                heldData = txIf.m_data;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start  = 1'b0;
        garble = 1'b0;
        checkVal({name, "_count"},       32'(got),        32'(NBYTES));
        checkVal({name, "_cen_cycles"},  32'(cenCnt),     32'(LAT));
        checkVal({name, "_first_valid"}, 32'(firstValid), 32'(LAT + 1));
        checkVal({name, "_done"},        32'(done),       32'd1);
        checkVal({name, "_end_valid"},   32'(txIf.m_valid), 32'd0);
        checkVal({name, "_end_busy"},    32'(busy),       32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        garble       = 1'b0;
        txIf.m_ready = 1'b0;
        junkVal      = '0;
        #2;
        resetAndCheck();

        applyStimulus(0);
        checkOutput("identity", 0, -1, 1'b0);
        // Starts below are issued in the previous run's done cycle.
        applyStimulus(1);
        checkOutput("neg_neg", 0, -1, 1'b0);
        applyStimulus(2);
        checkOutput("pos_neg", 0, -1, 1'b0);
        @(posedge clk);
        #1;
        checkVal("done_once",  32'(done),         32'd0);
        checkVal("idle_valid", 32'(txIf.m_valid), 32'd0);

        applyStimulus(3);
        checkOutput("backpressure", 1, -1, 1'b0);
        applyStimulus(4);
        checkOutput("start_ignored", 2, -1, 1'b1);
        applyStimulus(5);
        checkOutput("abort", 0, 7, 1'b0);
        applyStimulus(6);
        checkOutput("rerun", 2, -1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(7 + n);
            checkOutput("random", 2, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
